linreg_stats: RTL and testbench
===============================

Name: linreg_stats

Overview:
- Parametrised successor to the two-pass window statistics engine in the time-series predictor datapath.
- Walks an index window [si, ei) of an external sample memory through an index/value port.
- Pass 1 computes the window mean. Pass 2 computes either the mean absolute deviation or the peak absolute deviation from that mean, selected by mode.
- Adds configurable width, memory read latency, explicit error reporting and a busy flag.

Parameters:
- DATA_W, 32, sample width; samples are unsigned.
- IDX_W, 32, index width.
- MEM_LAT, 0, memory read latency in cycles; legal values 0 (combinational) or 1 (registered).
- ACC_W, DATA_W+IDX_W, accumulator and divider width (derived; do not override).

Ports:
- Clk  in  1  clock, all state on rising edge.
- Rst  in  1  synchronous active-high reset.
- start  in  1  request; sampled only in IDLE.
- si  in  IDX_W  first index, inclusive.
- ei  in  IDX_W  end index, exclusive.
- mode  in  1  0 = mean absolute deviation, 1 = peak absolute deviation.
- index  out  IDX_W  memory read address.
- value  in  DATA_W  memory read data for index, MEM_LAT cycles later.
- busy  out  1  high from the cycle after start is accepted until done.
- done  out  1  one-cycle completion pulse.
- err  out  1  valid with done; set when ei <= si.
- mean  out  DATA_W  floor(sum / N).
- deviation  out  DATA_W  result of the selected mode.
- count  out  IDX_W  N = ei - si.

Behaviour:
- Reset: one clock with Rst high.
  - All outputs go to 0 and the FSM goes to IDLE.
  - Reset mid-operation aborts the run. No done pulse follows, and outputs read 0 the next cycle.
- Start accept: start high in IDLE.
  - si, ei and mode are latched and N = ei - si is computed.
  - start is ignored while busy, and later changes to si/ei/mode have no effect on the run.
- Error case, ei <= si:
  - Next state is FIN.
  - err=1, mean=0, deviation=0, count=0.
  - No memory reads occur.
- States: IDLE -> SUM -> DIVM -> DEV -> DIVD (mode 0 only) -> FIN -> IDLE.
- SUM: N+MEM_LAT cycles.
  - index steps si, si+1, ..., ei-1, one per cycle.
  - value is accumulated zero-extended into an ACC_W-bit sum, MEM_LAT cycles after each address.
- DIVM: restoring divider, exactly ACC_W cycles.
  - mean = low DATA_W bits of floor(sum/N); the quotient always fits.
- DEV: N+MEM_LAT cycles, same address sequence as SUM.
  - d = |value - mean| in DATA_W bits.
  - mode 0 accumulates d into ACC_W bits.
  - mode 1 keeps the running maximum of d.
- DIVD, mode 0 only: ACC_W cycles; deviation = floor(dsum/N).
- FIN: exactly 1 cycle.
  - done=1; busy falls in the same cycle.
  - mean, deviation, count and err update in this cycle and hold until the next accepted start or reset.
- Latency from the start-accept edge to the done cycle:
  - mode 0: 2(N+MEM_LAT) + 2·ACC_W + 2 cycles.
  - mode 1: 2(N+MEM_LAT) + ACC_W + 2 cycles.
  - error case: 2 cycles.
- index between runs: holds the last driven address. It is 0 after reset.
- Arithmetic: no overflow is possible. N·(2^DATA_W−1) < 2^ACC_W, and the divisor N is never 0 on the non-error path.
- Back-to-back runs: start may be asserted in the cycle after FIN (IDLE). Holding start high continuously re-launches a run each time the block reaches IDLE.

Test Plan:
- Run 1 setup: memory[0..9] = 33,23,15,12,82,64,53,58,66,39, MEM_LAT=0, si=0, ei=10, mode=0, start for 1 cycle.
  - Required: mean=44, deviation=20, count=10, err=0.
  - done exactly 2·10+2·64+2 = 150 cycles after accept.
- Same memory, si=0, ei=10, mode=1 -> mean=44, deviation=38, done 86 cycles after accept. Then si=2, ei=5, mode=0 -> mean=36, deviation=30. Then the same window with mode=1 -> deviation=46.
- si=4, ei=5 -> mean=82, deviation=0, count=1. Then si=5, ei=5, and separately si=7, ei=3 -> err=1, mean=0, deviation=0, done 2 cycles after accept, index never changes.
- MEM_LAT=1 build with registered memory, si=0, ei=10, mode=0.
  - Required: mean=44, deviation=20, done 152 cycles after accept.
  - Address sequence 0..9 appears twice.
- Abort and ignore: Rst high for 1 cycle during DEV of a si=0, ei=10 run.
  - Required: all outputs 0 next cycle, no done, a fresh start completes normally.
  - Also: start pulsed while busy is ignored, and si/ei changes mid-run do not alter results.
- Max values: DATA_W=8, IDX_W=4, all samples 255, si=0, ei=15 -> mean=255, deviation=0 in both modes, no overflow.

Source files
------------

// File: rtl/linreg_stats.sv
// -----------------------------------------------------------------------------
// linreg_stats
//   Two-pass window statistics over an external sample memory.
//   Pass 1 sums samples value[si..ei-1] and divides by N = ei - si to get the
//   mean. Pass 2 walks the same window again and either averages (mode 0) or
//   takes the maximum of (mode 1) the absolute deviation from that mean.
//
// Ports
//   Clk, Rst      clock (rising edge) and synchronous active-high reset
//   start         run request, only looked at while IDLE
//   si, ei        window [si, ei), latched when start is accepted
//   mode          0 = mean absolute deviation, 1 = peak absolute deviation
//   index         memory read address (registered)
//   value         memory read data, MEM_LAT cycles after index
//   busy          high from the cycle after accept until the done cycle
//   done          one-cycle completion pulse
//   err           window empty or inverted (ei <= si), valid with done
//   mean          floor(sum / N)
//   deviation     result of the selected mode
//   count         N
//   dbg_state_o   current FSM state encoding
//
// Handshake: start is a level request sampled only in IDLE; there is no
// back-pressure. done is a single-cycle pulse; mean/deviation/count/err are
// updated on the same edge that raises done and hold until the next run ends
// or a reset. Holding start high relaunches a run every time IDLE is reached.
// -----------------------------------------------------------------------------
module linreg_stats #(
   parameter int DATA_W  = 32,
   parameter int IDX_W   = 32,
   parameter int MEM_LAT = 0,
   parameter int ACC_W   = DATA_W + IDX_W
) (
   input  logic              Clk,
   input  logic              Rst,
   input  logic              start,
   input  logic [IDX_W-1:0]  si,
   input  logic [IDX_W-1:0]  ei,
   input  logic              mode,
   output logic [IDX_W-1:0]  index,
   input  logic [DATA_W-1:0] value,
   output logic              busy,
   output logic              done,
   output logic              err,
   output logic [DATA_W-1:0] mean,
   output logic [DATA_W-1:0] deviation,
   output logic [IDX_W-1:0]  count,
   output logic [2:0]        dbg_state_o
);

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_SUM  = 3'd1,
      S_DIVM = 3'd2,
      S_DEV  = 3'd3,
      S_DIVD = 3'd4,
      S_FIN  = 3'd5
   } state_e;

   // Cycle counter must cover both a scan (N + MEM_LAT cycles) and a divide.
   localparam int CNT_W = ((IDX_W + 1) > ($clog2(ACC_W) + 1)) ?
                          (IDX_W + 1) : ($clog2(ACC_W) + 1);
   localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(ACC_W - 1);
   localparam logic [CNT_W-1:0] LAT_C    = CNT_W'(MEM_LAT);
   localparam logic [CNT_W-1:0] ONE_C    = CNT_W'(1);

   state_e              state_q;
   logic [IDX_W-1:0]    si_q;
   logic [IDX_W-1:0]    n_q;
   logic                mode_q;
   logic                err_pend_q;
   logic [CNT_W-1:0]    cnt_q;
   logic [ACC_W-1:0]    acc_q;       // running sum / dividend+quotient / max
   logic [ACC_W-1:0]    rem_q;       // divider partial remainder
   logic [DATA_W-1:0]   mean_int_q;  // mean used during the deviation pass

   logic [IDX_W-1:0]    index_q;
   logic                busy_q;
   logic                done_q;
   logic                err_q;
   logic [DATA_W-1:0]   mean_q;
   logic [DATA_W-1:0]   dev_q;
   logic [IDX_W-1:0]    count_q;

   logic [CNT_W-1:0]    n_ext;
   logic [CNT_W-1:0]    scan_last;
   logic [CNT_W-1:0]    addr_last;
   logic                lat_ok;
   logic [ACC_W-1:0]    divisor;
   logic [ACC_W:0]      rem_sh;
   logic                div_ge;
   logic [ACC_W-1:0]    rem_step_d;
   logic [ACC_W-1:0]    quo_step_d;
   logic [DATA_W-1:0]   abs_d;
   logic [ACC_W-1:0]    sum_d;
   logic [ACC_W-1:0]    dsum_d;
   logic [ACC_W-1:0]    dmax_d;

   assign n_ext     = CNT_W'(n_q);
   assign scan_last = n_ext + LAT_C - ONE_C;
   assign addr_last = n_ext - ONE_C;
   // With registered memory the first scan cycle carries stale read data.
   assign lat_ok    = (MEM_LAT == 0) ? 1'b1 : (cnt_q != '0);

   // One restoring-divider step: dividend bits leave acc_q at the top while
   // quotient bits enter at the bottom, so acc_q ends up holding the quotient.
   always_comb begin
      divisor    = ACC_W'(n_q);
      rem_sh     = {rem_q, acc_q[ACC_W-1]};
      div_ge     = (rem_sh >= {1'b0, divisor});
      // When div_ge the true difference is below the divisor, so the low
      // ACC_W bits of the modular subtraction are exact.
      rem_step_d = div_ge ? (rem_sh[ACC_W-1:0] - divisor) : rem_sh[ACC_W-1:0];
      quo_step_d = {acc_q[ACC_W-2:0], div_ge};
   end

   always_comb begin
      abs_d  = (value >= mean_int_q) ? (value - mean_int_q) : (mean_int_q - value);
      sum_d  = acc_q + ACC_W'(value);
      dsum_d = acc_q + ACC_W'(abs_d);
      dmax_d = (ACC_W'(abs_d) > acc_q) ? ACC_W'(abs_d) : acc_q;
   end

   always_ff @(posedge Clk) begin
      if (Rst) begin
         state_q    <= S_IDLE;
         si_q       <= '0;
         n_q        <= '0;
         mode_q     <= 1'b0;
         err_pend_q <= 1'b0;
         cnt_q      <= '0;
         acc_q      <= '0;
         rem_q      <= '0;
         mean_int_q <= '0;
         index_q    <= '0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         err_q      <= 1'b0;
         mean_q     <= '0;
         dev_q      <= '0;
         count_q    <= '0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (start) begin
                  si_q   <= si;
                  mode_q <= mode;
                  n_q    <= ei - si;
                  busy_q <= 1'b1;
                  cnt_q  <= '0;
                  acc_q  <= '0;
                  rem_q  <= '0;
                  if (ei <= si) begin
                     // Empty window: skip straight to FIN, index untouched.
                     err_pend_q <= 1'b1;
                     state_q    <= S_FIN;
                  end else begin
                     err_pend_q <= 1'b0;
                     index_q    <= si;
                     state_q    <= S_SUM;
                  end
               end
            end

            S_SUM: begin
               if (lat_ok) begin
                  acc_q <= sum_d;
               end
               if (cnt_q < addr_last) begin
                  index_q <= index_q + IDX_W'(1);
               end
               if (cnt_q == scan_last) begin
                  cnt_q   <= '0;
                  rem_q   <= '0;
                  state_q <= S_DIVM;
               end else begin
                  cnt_q <= cnt_q + ONE_C;
               end
            end

            S_DIVM: begin
               if (cnt_q == DIV_LAST) begin
                  mean_int_q <= quo_step_d[DATA_W-1:0];
                  acc_q      <= '0;
                  rem_q      <= '0;
                  cnt_q      <= '0;
                  index_q    <= si_q;
                  state_q    <= S_DEV;
               end else begin
                  acc_q <= quo_step_d;
                  rem_q <= rem_step_d;
                  cnt_q <= cnt_q + ONE_C;
               end
            end

            S_DEV: begin
               if (lat_ok) begin
                  acc_q <= mode_q ? dmax_d : dsum_d;
               end
               if (cnt_q < addr_last) begin
                  index_q <= index_q + IDX_W'(1);
               end
               if (cnt_q == scan_last) begin
                  cnt_q   <= '0;
                  rem_q   <= '0;
                  state_q <= mode_q ? S_FIN : S_DIVD;
               end else begin
                  cnt_q <= cnt_q + ONE_C;
               end
            end

            S_DIVD: begin
               acc_q <= quo_step_d;
               rem_q <= rem_step_d;
               if (cnt_q == DIV_LAST) begin
                  cnt_q   <= '0;
                  state_q <= S_FIN;
               end else begin
                  cnt_q <= cnt_q + ONE_C;
               end
            end

            S_FIN: begin
               done_q  <= 1'b1;
               busy_q  <= 1'b0;
               err_q   <= err_pend_q;
               count_q <= err_pend_q ? '0 : n_q;
               mean_q  <= err_pend_q ? '0 : mean_int_q;
               dev_q   <= err_pend_q ? '0 : acc_q[DATA_W-1:0];
               state_q <= S_IDLE;
            end

            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign index       = index_q;
   assign busy        = busy_q;
   assign done        = done_q;
   assign err         = err_q;
   assign mean        = mean_q;
   assign deviation   = dev_q;
   assign count       = count_q;
   assign dbg_state_o = state_q;

endmodule

// File: tb/tb_linreg_stats.sv
// -----------------------------------------------------------------------------
// tb_linreg_stats
//   Directed bench for linreg_stats. Instance A uses a combinational memory
//   (MEM_LAT=0), instance B the same contents behind a registered read
//   (MEM_LAT=1); both receive identical stimulus. Instance C is an 8-bit /
//   4-bit-index build filled with 255 for the full-scale case.
// -----------------------------------------------------------------------------
module tb_linreg_stats;

   // ---------------- clock / reset ----------------
   logic Clk = 1'b0;
   always #5 Clk = ~Clk;
   logic Rst;

   // ---------------- A/B signals ----------------
   logic        start_ab;
   logic [31:0] si_ab, ei_ab;
   logic        mode_ab;

   logic [31:0] index_a, value_a, mean_a, dev_a, count_a;
   logic        busy_a, done_a, err_a;
   logic [2:0]  dbg_a;
   logic [31:0] index_b, value_b, mean_b, dev_b, count_b;
   logic        busy_b, done_b, err_b;
   logic [2:0]  dbg_b;

   // ---------------- C signals ----------------
   logic        start_c;
   logic [3:0]  si_c, ei_c, index_c, count_c;
   logic        mode_c;
   logic [7:0]  value_c, mean_c, dev_c;
   logic        busy_c, done_c, err_c;
   logic [2:0]  dbg_c;

   // ---------------- memories ----------------
   logic [31:0] mem_ab [10] = '{33, 23, 15, 12, 82, 64, 53, 58, 66, 39};
   logic [7:0]  mem_c  [16] = '{default: 8'd255};

   always_comb value_a = (index_a < 32'd10) ? mem_ab[index_a[3:0]] : 32'd0;
   always @(posedge Clk) value_b <= (index_b < 32'd10) ? mem_ab[index_b[3:0]] : 32'd0;
   always_comb value_c = mem_c[index_c];

   // ---------------- DUTs ----------------
   linreg_stats #(.DATA_W(32), .IDX_W(32), .MEM_LAT(0)) u_a (
      .Clk(Clk), .Rst(Rst), .start(start_ab), .si(si_ab), .ei(ei_ab), .mode(mode_ab),
      .index(index_a), .value(value_a), .busy(busy_a), .done(done_a), .err(err_a),
      .mean(mean_a), .deviation(dev_a), .count(count_a), .dbg_state_o(dbg_a)
   );

   linreg_stats #(.DATA_W(32), .IDX_W(32), .MEM_LAT(1)) u_b (
      .Clk(Clk), .Rst(Rst), .start(start_ab), .si(si_ab), .ei(ei_ab), .mode(mode_ab),
      .index(index_b), .value(value_b), .busy(busy_b), .done(done_b), .err(err_b),
      .mean(mean_b), .deviation(dev_b), .count(count_b), .dbg_state_o(dbg_b)
   );

   linreg_stats #(.DATA_W(8), .IDX_W(4), .MEM_LAT(0)) u_c (
      .Clk(Clk), .Rst(Rst), .start(start_c), .si(si_c), .ei(ei_c), .mode(mode_c),
      .index(index_c), .value(value_c), .busy(busy_c), .done(done_c), .err(err_c),
      .mean(mean_c), .deviation(dev_c), .count(count_c), .dbg_state_o(dbg_c)
   );

   // ---------------- scoreboard ----------------
   int n_checks = 0;
   int n_fail   = 0;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // ---------------- drivers ----------------
   // Launch one run on A and B together and check results, latency and
   // (optionally) the address trace. Latency counts clock edges from the
   // accept edge (edge 1) to the edge after which done is seen high.
   task automatic run_ab(input string tag, input logic [31:0] s, input logic [31:0] e,
                         input logic m, input int exp_mean, input int exp_dev,
                         input int exp_cnt, input logic exp_err, input int exp_lat,
                         input bit disturb, input bit chk_addr);
      int          lat, lat_a, lat_b, moves_a, moves_b, exp_lat_b;
      bit          got_a, got_b;
      logic [31:0] prev_a, prev_b;
      logic [31:0] log_a[$];
      logic [31:0] log_b[$];
      logic [31:0] exp_q[$];
      exp_lat_b = exp_err ? exp_lat : exp_lat + 2;
      @(negedge Clk);
      si_ab = s; ei_ab = e; mode_ab = m; start_ab = 1'b1;
      prev_a = index_a; prev_b = index_b;
      lat = 0; lat_a = -1; lat_b = -1; moves_a = 0; moves_b = 0;
      got_a = 1'b0; got_b = 1'b0;
      while (!(got_a && got_b) && lat < 1000) begin
         @(posedge Clk); #1;
         lat++;
         start_ab = disturb && (lat == 10);
         if (disturb && lat == 10) begin
            si_ab = 32'd0; ei_ab = 32'd10; mode_ab = ~m;
         end
         if (lat == 1) begin
            check_eq({tag, "_busy_a"}, busy_a, 1);
            check_eq({tag, "_busy_b"}, busy_b, 1);
            log_a.push_back(index_a);
            log_b.push_back(index_b);
         end else begin
            if (!got_a && index_a !== prev_a) begin moves_a++; log_a.push_back(index_a); end
            if (!got_b && index_b !== prev_b) begin moves_b++; log_b.push_back(index_b); end
         end
         prev_a = index_a; prev_b = index_b;
         if (!got_a && done_a === 1'b1) begin
            got_a = 1'b1; lat_a = lat;
            check_eq({tag, "_mean_a"},  mean_a,  exp_mean);
            check_eq({tag, "_dev_a"},   dev_a,   exp_dev);
            check_eq({tag, "_count_a"}, count_a, exp_cnt);
            check_eq({tag, "_err_a"},   err_a,   exp_err);
            check_eq({tag, "_busyfall_a"}, busy_a, 0);
         end
         if (!got_b && done_b === 1'b1) begin
            got_b = 1'b1; lat_b = lat;
            check_eq({tag, "_mean_b"},  mean_b,  exp_mean);
            check_eq({tag, "_dev_b"},   dev_b,   exp_dev);
            check_eq({tag, "_count_b"}, count_b, exp_cnt);
            check_eq({tag, "_err_b"},   err_b,   exp_err);
         end
      end
      start_ab = 1'b0;
      check_eq({tag, "_lat_a"}, lat_a, exp_lat);
      check_eq({tag, "_lat_b"}, lat_b, exp_lat_b);
      if (exp_err) begin
         check_eq({tag, "_idxmoves_a"}, moves_a, 0);
         check_eq({tag, "_idxmoves_b"}, moves_b, 0);
      end
      if (chk_addr) begin
         for (int r = 0; r < 2; r++)
            for (int i = int'(s); i < int'(e); i++) exp_q.push_back(i);
         check_eq({tag, "_addrlen_a"}, log_a.size(), exp_q.size());
         check_eq({tag, "_addrlen_b"}, log_b.size(), exp_q.size());
         for (int i = 0; i < exp_q.size(); i++) begin
            if (i < log_a.size()) check_eq($sformatf("%s_addr_a%0d", tag, i), log_a[i], exp_q[i]);
            if (i < log_b.size()) check_eq($sformatf("%s_addr_b%0d", tag, i), log_b[i], exp_q[i]);
         end
      end
      @(posedge Clk); #1;
      check_eq({tag, "_pulse_a"}, done_a, 0);
      check_eq({tag, "_pulse_b"}, done_b, 0);
   endtask

   task automatic check_zero_ab(input string tag);
      check_eq({tag, "_index_a"}, index_a, 0);
      check_eq({tag, "_busy_a"},  busy_a,  0);
      check_eq({tag, "_done_a"},  done_a,  0);
      check_eq({tag, "_err_a"},   err_a,   0);
      check_eq({tag, "_mean_a"},  mean_a,  0);
      check_eq({tag, "_dev_a"},   dev_a,   0);
      check_eq({tag, "_count_a"}, count_a, 0);
      check_eq({tag, "_index_b"}, index_b, 0);
      check_eq({tag, "_busy_b"},  busy_b,  0);
      check_eq({tag, "_err_b"},   err_b,   0);
      check_eq({tag, "_mean_b"},  mean_b,  0);
      check_eq({tag, "_dev_b"},   dev_b,   0);
      check_eq({tag, "_count_b"}, count_b, 0);
   endtask

   // Reset pulse in the middle of the deviation pass of a 0..10 run.
   task automatic abort_ab();
      int dones;
      @(negedge Clk);
      si_ab = 32'd0; ei_ab = 32'd10; mode_ab = 1'b0; start_ab = 1'b1;
      for (int i = 0; i < 80; i++) begin
         @(posedge Clk); #1;
         start_ab = 1'b0;
      end
      check_eq("abort_inrun_busy_a", busy_a, 1);
      Rst = 1'b1;
      @(posedge Clk); #1;
      Rst = 1'b0;
      check_zero_ab("abort");
      dones = 0;
      for (int i = 0; i < 200; i++) begin
         @(posedge Clk); #1;
         if (done_a === 1'b1 || done_b === 1'b1) dones++;
      end
      check_eq("abort_no_done", dones, 0);
      check_eq("abort_idle_busy_a", busy_a, 0);
   endtask

   task automatic run_c(input string tag, input logic m, input int exp_mean,
                        input int exp_dev, input int exp_lat);
      int lat;
      bit got;
      @(negedge Clk);
      si_c = 4'd0; ei_c = 4'd15; mode_c = m; start_c = 1'b1;
      lat = 0; got = 1'b0;
      while (!got && lat < 1000) begin
         @(posedge Clk); #1;
         lat++;
         start_c = 1'b0;
         if (done_c === 1'b1) got = 1'b1;
      end
      check_eq({tag, "_done"},  got,     1);
      check_eq({tag, "_lat"},   lat,     exp_lat);
      check_eq({tag, "_mean"},  mean_c,  exp_mean);
      check_eq({tag, "_dev"},   dev_c,   exp_dev);
      check_eq({tag, "_count"}, count_c, 15);
      check_eq({tag, "_err"},   err_c,   0);
   endtask

   // ---------------- main sequence ----------------
   initial begin
      Rst = 1'b1;
      start_ab = 1'b0; si_ab = '0; ei_ab = '0; mode_ab = 1'b0;
      start_c = 1'b0; si_c = '0; ei_c = '0; mode_c = 1'b0;
      repeat (3) @(posedge Clk);
      @(negedge Clk);
      Rst = 1'b0;
      check_zero_ab("reset");
      check_eq("reset_state_a", dbg_a, 0);
      check_eq("reset_index_c", index_c, 0);
      check_eq("reset_mean_c", mean_c, 0);
      check_eq("reset_busy_c", busy_c, 0);

      //      tag   si  ei  m  mean dev cnt err lat  disturb addr
      run_ab("r1",  0, 10, 0, 44,  20, 10, 0, 150, 0, 1);
      run_ab("r2",  0, 10, 1, 44,  38, 10, 0,  86, 0, 0);
      run_ab("r3",  2,  5, 0, 36,  30,  3, 0, 136, 1, 0);
      run_ab("r4",  2,  5, 1, 36,  46,  3, 0,  72, 0, 0);
      run_ab("r5",  4,  5, 0, 82,   0,  1, 0, 132, 0, 0);
      check_eq("hold_index_a", index_a, 4);
      check_eq("hold_index_b", index_b, 4);
      run_ab("e1",  5,  5, 0,  0,   0,  0, 1,   2, 0, 0);
      run_ab("e2",  7,  3, 1,  0,   0,  0, 1,   2, 0, 0);
      check_eq("err_index_a", index_a, 4);
      check_eq("err_index_b", index_b, 4);
      run_ab("r6",  0, 10, 1, 44,  38, 10, 0,  86, 0, 0);
      abort_ab();
      run_ab("r7",  0, 10, 0, 44,  20, 10, 0, 150, 0, 0);

      run_c("c0", 1'b0, 255, 0, 56);
      run_c("c1", 1'b1, 255, 0, 44);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog expired");
   end

endmodule
